gpio_bank: RTL and testbench
============================

// Module: gpio_bank
// PURPOSE
//  Parametrised GPIO peripheral on the common memory bus; replaces ad-hoc LED/button/PMOD glue in the SoC top.
//  WIDTH pins, each with output latch, output-enable, synchronised and optionally debounced input.
//  Atomic set/clear/toggle writes; per-pin rising/falling edge interrupt with W1C pending register.
//  One instance per pin group (LEDs, buttons, PMOD); selected by the top-level decoder via sel_in.
// PARAMETERS
//  WIDTH        8    pin count, 1..32; register bits >= WIDTH read 0, writes ignored
//  SYNC_STAGES  2    input synchroniser depth, >= 2
//  DEBOUNCE_LOG2 0   0: no debounce; N>0: sample tick every 2^N clk cycles
//  RESET_OUT    '0   OUT register reset value [WIDTH-1:0]
//  RESET_OE     '0   OE register reset value [WIDTH-1:0]
// PORTS
//  clk             in   1      system clock
//  reset           in   1      synchronous, active-high reset
//  address_in      in   32     bus address; only [5:2] decoded
//  sel_in          in   1      block selected by top-level decoder
//  read_in         in   1      read strobe (no read side effects; informational)
//  read_value_out  out  32     read data; 0 when sel_in=0 (wired-OR bus)
//  write_mask_in   in   4      byte-lane write enables; write when sel_in && |mask
//  write_value_in  in   32     write data
//  ready_out       out  1      = sel_in, same cycle (zero wait state)
//  gpio_in         in   WIDTH  asynchronous pin inputs
//  gpio_out        out  WIDTH  = OUT register
//  gpio_oe         out  WIDTH  = OE register (1 = drive)
//  irq_out         out  1      registered; |PEND
// BEHAVIOUR
//  Register map (word offset): 0x00 OUT rw | 0x04 OE rw | 0x08 IN ro (debounced) | 0x0C SET wo | 0x10 CLR wo
//   0x14 TOG wo | 0x18 RISE_EN rw | 0x1C FALL_EN rw | 0x20 PEND rw1c | 0x24-0x3C read 0, writes ignored.
//  Write-only regs read 0. All writes honour byte lanes: only bits in enabled lanes affected.
//  SET: OUT|=d; CLR: OUT&=~d; TOG: OUT^=d (masked by lanes); take effect on gpio_out next cycle.
//  Read path combinational from current register state; ready_out asserted in the select cycle.
//  Input path: gpio_in -> SYNC_STAGES flops -> debouncer -> state register IN.
//  Debounce (DEBOUNCE_LOG2>0): shared free-running prescaler, tick when counter wraps;
//   per pin, on tick: IN takes sample only if equal to previous tick sample (2 consecutive agreeing ticks).
//   DEBOUNCE_LOG2=0: IN = last sync stage, updated every cycle.
//  Edge detect: rise = IN_next & ~IN, fall = ~IN_next & IN, evaluated in the cycle IN updates.
//  PEND[i] sets on (rise[i]&RISE_EN[i]) | (fall[i]&FALL_EN[i]); edges with enable=0 are dropped, not latched.
//  PEND W1C: written 1 bits clear; simultaneous set and clear of same bit -> set wins.
//  irq_out = |PEND, registered: asserts 1 cycle after PEND bit sets, deasserts 1 cycle after last clear.
//  Clearing an enable does not clear its PEND bit.
//  Latency: pin change to IN visible = SYNC_STAGES+1 cycles (no debounce); to irq_out +1 more.
//  Reset: OUT=RESET_OUT, OE=RESET_OE, RISE_EN=FALL_EN=PEND=0, sync flops/IN/samples=0, prescaler=0, irq_out=0.
//   Reset mid-activity discards in-flight edges; pins held high after reset rise IN with no PEND (enables 0).
//  Prescaler wraps naturally at 2^DEBOUNCE_LOG2; no overflow state.
// STRUCTURE
//  gpio_pkg: register offset constants (GPIO_OUT..GPIO_PEND), offset-field width.
//  Sub-module gpio_debounce #(WIDTH,SYNC_STAGES,DEBOUNCE_LOG2): sync chain, prescaler, stable-sample
//   logic; outputs IN state plus rise/fall strobes. gpio_bank holds bus decode, registers, PEND, irq.
// TESTING
//  1 Reset with RESET_OUT=8'hA5, RESET_OE=8'h0F -> gpio_out=A5, gpio_oe=0F, irq_out=0, all reads match.
//  2 Write OUT=0x0F; SET 0xF0; CLR 0x03; TOG 0x81 -> OUT reads 0x7D; SET/CLR/TOG read 0.
//  3 WIDTH=8, write 0xFFFF_FFFF to OE with mask 4'b0010 -> OE unchanged (lane 1 above WIDTH), reads 0 upper bits.
//  4 DEBOUNCE_LOG2=0, RISE_EN=0x01, gpio_in[0] 0->1 -> IN[0]=1 after 3 cycles, PEND=0x01, irq_out next cycle;
//    write PEND=0x01 -> irq_out drops 1 cycle later.
//  5 DEBOUNCE_LOG2=4, gpio_in[1] glitch of 10 cycles -> IN and PEND unchanged; held 48 cycles -> IN[1]=1.
//  6 FALL_EN=0x04, W1C of PEND[2] in same cycle as new falling edge on pin 2 -> PEND[2] stays 1.

Source files
------------

// File: rtl/gpio_pkg.sv
// gpio_pkg: register word offsets shared by the GPIO bank and its users.
package gpio_pkg;
  localparam int OFF_W = 4;
  localparam logic [OFF_W-1:0] GPIO_OUT     = 4'h0;
  localparam logic [OFF_W-1:0] GPIO_OE      = 4'h1;
  localparam logic [OFF_W-1:0] GPIO_IN      = 4'h2;
  localparam logic [OFF_W-1:0] GPIO_SET     = 4'h3;
  localparam logic [OFF_W-1:0] GPIO_CLR     = 4'h4;
  localparam logic [OFF_W-1:0] GPIO_TOG     = 4'h5;
  localparam logic [OFF_W-1:0] GPIO_RISE_EN = 4'h6;
  localparam logic [OFF_W-1:0] GPIO_FALL_EN = 4'h7;
  localparam logic [OFF_W-1:0] GPIO_PEND    = 4'h8;
endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce: input synchroniser, optional tick-based debouncer and edge strobes.
module gpio_debounce #(
  parameter int WIDTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_LOG2 = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pins,
  output logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);
  localparam int L = SYNC_STAGES - 1;
  logic [WIDTH-1:0] sync [SYNC_STAGES];
  logic [WIDTH-1:0] nxt;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '{default: '0};
      state <= '0;
    end else begin
      sync[0] <= pins;
      for (int k = 1; k < SYNC_STAGES; k++) sync[k] <= sync[k-1];
      state <= nxt;
    end
  end
  generate
    if (DEBOUNCE_LOG2 == 0) begin : g_direct
      assign nxt = sync[L];
    end else begin : g_deb
      logic [DEBOUNCE_LOG2-1:0] cnt;
      logic [WIDTH-1:0] samp;
      logic [WIDTH-1:0] agree;
      logic tick;
      assign tick = &cnt;
      assign agree = ~(sync[L] ^ samp);
      // a pin moves only when two consecutive tick samples agree
      assign nxt = tick ? (agree & sync[L]) | (~agree & state) : state;
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt <= '0;
          samp <= '0;
        end else begin
          cnt <= cnt + 1'b1;
          if (tick) samp <= sync[L];
        end
      end
    end
  endgenerate
  assign rise = nxt & ~state;
  assign fall = ~nxt & state;
endmodule

// File: rtl/gpio_bank.sv
// gpio_bank: bus-mapped GPIO pin group with atomic bit ops and edge interrupts.
module gpio_bank
  import gpio_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_LOG2 = 0,
  parameter logic [WIDTH-1:0] RESET_OUT = '0,
  parameter logic [WIDTH-1:0] RESET_OE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      address_in,
  input  logic             sel_in,
  input  logic             read_in,
  output logic [31:0]      read_value_out,
  input  logic [3:0]       write_mask_in,
  input  logic [31:0]      write_value_in,
  output logic             ready_out,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq_out
);
  logic [WIDTH-1:0] out_q, oe_q, rise_en, fall_en, pend, in_state, rise, fall;
  logic [WIDTH-1:0] lm, d, out_n, oe_n, re_n, fe_n, pend_n;
  logic [OFF_W-1:0] off;
  logic [31:0] rv;
  logic we;
  logic unused;
  assign unused = ^{read_in, address_in, write_mask_in, write_value_in};
  assign off = address_in[5:2];
  assign we = sel_in && |write_mask_in;
  always_comb begin
    lm = '0;
    for (int i = 0; i < WIDTH; i++) lm[i] = write_mask_in[i/8];
  end
  assign d = write_value_in[WIDTH-1:0] & lm;
  gpio_debounce #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_LOG2(DEBOUNCE_LOG2)) u_deb (
    .clk(clk), .reset(reset), .pins(gpio_in), .state(in_state), .rise(rise), .fall(fall)
  );
  always_comb begin
    out_n = !we ? out_q :
            off == GPIO_OUT ? (out_q & ~lm) | d :
            off == GPIO_SET ? out_q | d :
            off == GPIO_CLR ? out_q & ~d :
            off == GPIO_TOG ? out_q ^ d : out_q;
    oe_n = we && off == GPIO_OE ? (oe_q & ~lm) | d : oe_q;
    re_n = we && off == GPIO_RISE_EN ? (rise_en & ~lm) | d : rise_en;
    fe_n = we && off == GPIO_FALL_EN ? (fall_en & ~lm) | d : fall_en;
    // new edges are OR-ed after the W1C so a coincident set wins
    pend_n = (pend & ~(we && off == GPIO_PEND ? d : '0)) | (rise & rise_en) | (fall & fall_en);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= RESET_OUT;
      oe_q <= RESET_OE;
      rise_en <= '0;
      fall_en <= '0;
      pend <= '0;
      irq_out <= 1'b0;
    end else begin
      out_q <= out_n;
      oe_q <= oe_n;
      rise_en <= re_n;
      fall_en <= fe_n;
      pend <= pend_n;
      irq_out <= |pend;
    end
  end
  always_comb begin
    rv = '0;
    case (off)
      GPIO_OUT:     rv = 32'(out_q);
      GPIO_OE:      rv = 32'(oe_q);
      GPIO_IN:      rv = 32'(in_state);
      GPIO_RISE_EN: rv = 32'(rise_en);
      GPIO_FALL_EN: rv = 32'(fall_en);
      GPIO_PEND:    rv = 32'(pend);
      default:      rv = '0;
    endcase
  end
  assign read_value_out = sel_in ? rv : '0;
  assign ready_out = sel_in;
  assign gpio_out = out_q;
  assign gpio_oe = oe_q;
endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: directed checks of two GPIO banks (direct input and debounced input).
module tb_gpio_bank;
  logic clk = 0, reset = 1;
  logic [31:0] address = 0, wdata = 0, rv_a, rv_b;
  logic [3:0] wmask = 0;
  logic sel_a = 0, sel_b = 0, rdy_a, rdy_b, irq_a, irq_b;
  logic [7:0] gin_a = 0, gin_b = 0, gout_a, goe_a, gout_b, goe_b;
  int n_chk = 0, n_pass = 0;
  logic [31:0] v;
  logic seen;
  always #5 clk = ~clk;
  gpio_bank #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_LOG2(0), .RESET_OUT(8'hA5), .RESET_OE(8'h0F)) dut_a (
    .clk(clk), .reset(reset), .address_in(address), .sel_in(sel_a), .read_in(sel_a),
    .read_value_out(rv_a), .write_mask_in(wmask), .write_value_in(wdata), .ready_out(rdy_a),
    .gpio_in(gin_a), .gpio_out(gout_a), .gpio_oe(goe_a), .irq_out(irq_a)
  );
  gpio_bank #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_LOG2(4)) dut_b (
    .clk(clk), .reset(reset), .address_in(address), .sel_in(sel_b), .read_in(sel_b),
    .read_value_out(rv_b), .write_mask_in(wmask), .write_value_in(wdata), .ready_out(rdy_b),
    .gpio_in(gin_b), .gpio_out(gout_b), .gpio_oe(goe_b), .irq_out(irq_b)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask
  task automatic tk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wr(input logic b, input logic [3:0] off, input logic [31:0] data, input logic [3:0] m);
    address = {26'b0, off, 2'b0};
    wdata = data;
    wmask = m;
    sel_a = !b;
    sel_b = b;
    tk(1);
    wmask = 0;
    sel_a = 0;
    sel_b = 0;
  endtask
  task automatic rd(input logic b, input logic [3:0] off, output logic [31:0] val);
    address = {26'b0, off, 2'b0};
    sel_a = !b;
    sel_b = b;
    #1;
    val = b ? rv_b : rv_a;
    sel_a = 0;
    sel_b = 0;
  endtask
  initial begin
    tk(3);
    reset = 0;
    check("rst_gpio_out", 32'(gout_a), 32'hA5);
    check("rst_gpio_oe", 32'(goe_a), 32'h0F);
    check("rst_irq", 32'(irq_a), 0);
    rd(0, 4'h0, v); check("rst_out", v, 32'hA5);
    rd(0, 4'h1, v); check("rst_oe", v, 32'h0F);
    rd(0, 4'h2, v); check("rst_in", v, 0);
    rd(0, 4'h6, v); check("rst_rise_en", v, 0);
    rd(0, 4'h8, v); check("rst_pend", v, 0);
    address = 0;
    #1 check("unsel_read", rv_a, 0);
    check("unsel_ready", 32'(rdy_a), 0);
    sel_a = 1;
    #1 check("sel_ready", 32'(rdy_a), 1);
    sel_a = 0;
    wr(0, 4'h0, 32'h0F, 4'hF);
    wr(0, 4'h3, 32'hF0, 4'hF);
    wr(0, 4'h4, 32'h03, 4'hF);
    wr(0, 4'h5, 32'h81, 4'hF);
    rd(0, 4'h0, v); check("atomic_out", v, 32'h7D);
    check("atomic_pins", 32'(gout_a), 32'h7D);
    rd(0, 4'h3, v); check("set_reads0", v, 0);
    rd(0, 4'h4, v); check("clr_reads0", v, 0);
    rd(0, 4'h5, v); check("tog_reads0", v, 0);
    wr(0, 4'h5, 32'hFFFF_FF00, 4'hE);
    rd(0, 4'h0, v); check("tog_lane_masked", v, 32'h7D);
    wr(0, 4'h1, 32'hFFFF_FFFF, 4'b0010);
    rd(0, 4'h1, v); check("oe_upper_lane", v, 32'h0F);
    wr(0, 4'h1, 32'hFFFF_FF33, 4'b0001);
    rd(0, 4'h1, v); check("oe_lane0", v, 32'h33);
    check("oe_pins", 32'(goe_a), 32'h33);
    wr(0, 4'hA, 32'hFFFF_FFFF, 4'hF);
    rd(0, 4'hA, v); check("reserved_reads0", v, 0);
    wr(0, 4'h6, 32'h01, 4'h1);
    gin_a[0] = 1;
    tk(2);
    rd(0, 4'h2, v); check("in_lat_2", v, 0);
    tk(1);
    rd(0, 4'h2, v); check("in_lat_3", v, 32'h01);
    rd(0, 4'h8, v); check("pend_rise", v, 32'h01);
    check("irq_not_yet", 32'(irq_a), 0);
    tk(1);
    check("irq_set", 32'(irq_a), 1);
    wr(0, 4'h8, 32'h01, 4'h1);
    rd(0, 4'h8, v); check("pend_w1c", v, 0);
    check("irq_hold", 32'(irq_a), 1);
    tk(1);
    check("irq_drop", 32'(irq_a), 0);
    gin_a[0] = 0;
    tk(4);
    rd(0, 4'h8, v); check("fall_disabled", v, 0);
    wr(0, 4'h7, 32'h04, 4'h1);
    gin_a[2] = 1;
    tk(4);
    rd(0, 4'h8, v); check("rise_disabled_pin2", v, 0);
    gin_a[2] = 0;
    tk(4);
    rd(0, 4'h8, v); check("pend_fall2", v, 32'h04);
    gin_a[2] = 1;
    tk(4);
    gin_a[2] = 0;
    tk(2);
    wr(0, 4'h8, 32'h04, 4'h1);
    rd(0, 4'h8, v); check("set_wins_w1c", v, 32'h04);
    wr(0, 4'h7, 32'h00, 4'h1);
    rd(0, 4'h8, v); check("en_clear_keeps_pend", v, 32'h04);
    wr(0, 4'h8, 32'h04, 4'h1);
    rd(0, 4'h8, v); check("pend_cleared", v, 0);
    wr(1, 4'h6, 32'h02, 4'h1);
    gin_b[1] = 1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tk(1);
      rd(1, 4'h2, v);
      seen |= (v != 0);
    end
    gin_b[1] = 0;
    for (int i = 0; i < 40; i++) begin
      tk(1);
      rd(1, 4'h2, v);
      seen |= (v != 0);
    end
    check("glitch_in", 32'(seen), 0);
    rd(1, 4'h8, v); check("glitch_pend", v, 0);
    gin_b[1] = 1;
    tk(16);
    rd(1, 4'h2, v); check("db_not_yet", v, 0);
    tk(32);
    rd(1, 4'h2, v); check("db_in_stable", v, 32'h02);
    rd(1, 4'h8, v); check("db_pend", v, 32'h02);
    tk(1);
    check("db_irq", 32'(irq_b), 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
